// File: rtl/vector_adder_issue_ctrl.sv
// Issue controller for vector_adder: accepts a row, adds a bias snapshot through the
// adder, supervises the adder with a timeout and forwards the result on a valid/ready stream.
module vector_adder_issue_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_UNITS  = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic                                  bias_wr_en_i,
   input  logic [((NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1)-1:0] bias_wr_idx_i,
   input  logic [DATA_WIDTH-1:0]                 bias_wr_data_i,
   input  logic                                  in_valid_i,
   output logic                                  in_ready_o,
   input  logic [DATA_WIDTH-1:0]                 in_x_i [NUM_UNITS],
   input  logic [NUM_UNITS-1:0]                  in_mask_i,
   output logic                                  add_start_o,
   output logic [NUM_UNITS-1:0]                  add_active_units_o,
   output logic [DATA_WIDTH-1:0]                 add_x_o [NUM_UNITS],
   output logic [DATA_WIDTH-1:0]                 add_bias_o [NUM_UNITS],
   input  logic [DATA_WIDTH-1:0]                 add_out_i [NUM_UNITS],
   input  logic                                  add_ready_i,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output logic [DATA_WIDTH-1:0]                 out_data_o [NUM_UNITS],
   output logic [NUM_UNITS-1:0]                  out_mask_o,
   output logic                                  timeout_err_o
);

   localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_e;

   state_e                  state_q;
   logic                    in_ready_q;
   logic                    add_start_q;
   logic [NUM_UNITS-1:0]    add_active_q;
   logic [DATA_WIDTH-1:0]   add_x_q    [NUM_UNITS];
   logic [DATA_WIDTH-1:0]   add_bias_q [NUM_UNITS];
   logic [DATA_WIDTH-1:0]   bias_q     [NUM_UNITS];
   logic [DATA_WIDTH-1:0]   out_data_q [NUM_UNITS];
   logic [DATA_WIDTH-1:0]   result_d   [NUM_UNITS];
   logic [NUM_UNITS-1:0]    out_mask_q;
   logic                    out_valid_q;
   logic                    timeout_q;
   logic [CNT_W-1:0]        cnt_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_UNITS; i++) bias_q[i] <= '0;
      end else if (bias_wr_en_i) begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (bias_wr_idx_i == IDX_W'(i)) bias_q[i] <= bias_wr_data_i;
         end
      end
   end

   // Inactive lanes may carry anything from the adder, so they are forced to zero.
   always_comb begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         result_d[i] = add_active_q[i] ? add_out_i[i] : '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         in_ready_q   <= 1'b0;
         add_start_q  <= 1'b0;
         add_active_q <= '0;
         out_mask_q   <= '0;
         out_valid_q  <= 1'b0;
         timeout_q    <= 1'b0;
         cnt_q        <= '0;
         for (int i = 0; i < NUM_UNITS; i++) begin
            add_x_q[i]    <= '0;
            add_bias_q[i] <= '0;
            out_data_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid_i && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  if (in_mask_i != '0) begin
                     state_q      <= S_ISSUE;
                     add_start_q  <= 1'b1;
                     add_active_q <= in_mask_i;
                     for (int i = 0; i < NUM_UNITS; i++) begin
                        add_x_q[i]    <= in_x_i[i];
                        add_bias_q[i] <= bias_q[i];
                     end
                  end else begin
                     state_q    <= S_OUTPUT;
                     out_mask_q <= '0;
                     for (int i = 0; i < NUM_UNITS; i++) out_data_q[i] <= '0;
                  end
               end
            end
            S_ISSUE: begin
               add_start_q <= 1'b0;
               state_q     <= S_WAIT;
            end
            // Ready is only trusted here; one seen during ISSUE belongs to an older request.
            S_WAIT: begin
               if (add_ready_i || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                  state_q      <= S_OUTPUT;
                  cnt_q        <= '0;
                  add_active_q <= '0;
                  out_mask_q   <= add_ready_i ? add_active_q : '0;
                  timeout_q    <= timeout_q | ~add_ready_i;
                  for (int i = 0; i < NUM_UNITS; i++) begin
                     out_data_q[i] <= add_ready_i ? result_d[i] : '0;
                     add_x_q[i]    <= '0;
                     add_bias_q[i] <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_OUTPUT: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o         = in_ready_q;
   assign add_start_o        = add_start_q;
   assign add_active_units_o = add_active_q;
   assign add_x_o            = add_x_q;
   assign add_bias_o         = add_bias_q;
   assign out_valid_o        = out_valid_q;
   assign out_data_o         = out_data_q;
   assign out_mask_o         = out_mask_q;
   assign timeout_err_o      = timeout_q;

endmodule

// File: tb/tb_vector_adder_issue_ctrl.sv
// Bench for vector_adder_issue_ctrl with a behavioural FP16 vector_adder (ready 3 cycles
// after start) and a queue of expected result rows checked at each output handshake.
module tb_vector_adder_issue_ctrl;

   localparam int DW = 16;
   localparam int NU = 4;
   localparam int TO = 8;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  mask;
   } row_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            bias_wr_en;
   logic [1:0]      bias_wr_idx;
   logic [DW-1:0]   bias_wr_data;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_x [NU];
   logic [NU-1:0]   in_mask;
   logic            add_start;
   logic [NU-1:0]   add_active_units;
   logic [DW-1:0]   add_x [NU];
   logic [DW-1:0]   add_bias [NU];
   logic [DW-1:0]   add_out [NU];
   logic            add_ready = 1'b0;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data [NU];
   logic [NU-1:0]   out_mask;
   logic            timeout_err;

   int   checks = 0;
   int   failures = 0;
   int   startCount = 0;
   int   popCount = 0;
   bit   adderMute = 1'b0;
   bit   staleReady = 1'b0;
   int   addCnt = -1;
   logic [DW-1:0] sum [NU];
   row_t sbQ [$];
   row_t monE;
   logic [63:0] monD;

   vector_adder_issue_ctrl #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .TIMEOUT(TO)) dut (
      .clk_i(clk), .reset_i(reset),
      .bias_wr_en_i(bias_wr_en), .bias_wr_idx_i(bias_wr_idx), .bias_wr_data_i(bias_wr_data),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x), .in_mask_i(in_mask),
      .add_start_o(add_start), .add_active_units_o(add_active_units),
      .add_x_o(add_x), .add_bias_o(add_bias), .add_out_i(add_out), .add_ready_i(add_ready),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_mask_o(out_mask), .timeout_err_o(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic real h2r(input logic [15:0] h);
      real r;
      int  e;
      e = int'(h[14:10]);
      if (e == 0) return 0.0;
      r = 1.0 + real'(h[9:0]) / 1024.0;
      while (e > 15) begin r = r * 2.0; e--; end
      while (e < 15) begin r = r / 2.0; e++; end
      return h[15] ? -r : r;
   endfunction

   function automatic logic [15:0] r2h(input real v);
      logic s;
      int   e;
      int   m;
      real  a;
      if (v == 0.0) return 16'h0000;
      s = (v < 0.0);
      a = s ? -v : v;
      e = 15;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0) begin a = a * 2.0; e--; end
      m = int'((a - 1.0) * 1024.0);
      if (m == 1024) begin m = 0; e++; end
      return {s, e[4:0], m[9:0]};
   endfunction

   function automatic logic [15:0] fpAdd(input logic [15:0] a, input logic [15:0] b);
      return r2h(h2r(a) + h2r(b));
   endfunction

   function automatic logic [63:0] packOut();
      logic [63:0] d;
      for (int i = 0; i < NU; i++) d[16*i +: 16] = out_data[i];
      return d;
   endfunction

   // Behavioural vector_adder: sums every lane, pulses ready three cycles after start.
   always @(negedge clk) begin
      add_ready = 1'b0;
      if (addCnt > 0) begin
         addCnt--;
         if (addCnt == 0) begin
            add_ready = 1'b1;
            for (int i = 0; i < NU; i++) add_out[i] = sum[i];
            addCnt = -1;
         end
      end
      if (add_start === 1'b1) begin
         startCount++;
         if (!adderMute) begin
            for (int i = 0; i < NU; i++) sum[i] = fpAdd(add_x[i], add_bias[i]);
            addCnt = 3;
         end
         if (staleReady) begin
            add_ready = 1'b1;
            for (int i = 0; i < NU; i++) add_out[i] = 16'hDEAD;
         end
      end
   end

   // Scoreboard: compare every handshaken output row against the oldest expectation.
   always @(negedge clk) begin
      #2;
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sbQ.size() == 0) begin
            checkOutput("sb_unexpected_row", 64'd1, 64'd0);
         end else begin
            monE = sbQ.pop_front();
            monD = packOut();
            checkOutput("out_data", monD, monE.data);
            checkOutput("out_mask", {60'd0, out_mask}, {60'd0, monE.mask});
            popCount++;
         end
      end
   end

   task automatic applyStimulus(input logic [63:0] x, input logic [3:0] mask,
                                input logic [63:0] expData, input logic [3:0] expMask);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) checkOutput("in_ready_wait", 64'd0, 64'd1);
      for (int i = 0; i < NU; i++) in_x[i] = x[16*i +: 16];
      in_mask  = mask;
      in_valid = 1'b1;
      sbQ.push_back('{expData, expMask});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic writeBias(input logic [1:0] idx, input logic [15:0] data);
      bias_wr_en   = 1'b1;
      bias_wr_idx  = idx;
      bias_wr_data = data;
      @(negedge clk);
      bias_wr_en = 1'b0;
   endtask

   task automatic waitOutValid(output int k);
      k = 0;
      while (out_valid !== 1'b1 && k < 60) begin @(negedge clk); k++; end
      if (k >= 60) checkOutput("out_valid_wait", 64'd0, 64'd1);
   endtask

   task automatic waitDrain(input int target);
      int n = 0;
      while (popCount < target && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) checkOutput("drain_wait", 64'(popCount), 64'(target));
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int k;
      int bad;
      int s0;
      logic [63:0] held;

      reset = 1'b1; bias_wr_en = 1'b0; bias_wr_idx = '0; bias_wr_data = '0;
      in_valid = 1'b0; in_mask = '0; out_ready = 1'b1;
      for (int i = 0; i < NU; i++) begin in_x[i] = '0; add_out[i] = '0; end
      repeat (2) @(negedge clk);
      checkOutput("reset_outputs",
                  {56'd0, in_ready, out_valid, add_start, timeout_err, add_active_units}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

      // Masked add with a stale ready in ISSUE and ten cycles of backpressure.
      writeBias(2'd3, 16'h4000); writeBias(2'd2, 16'h3C00);
      writeBias(2'd1, 16'h0000); writeBias(2'd0, 16'h3C00);
      out_ready = 1'b0; staleReady = 1'b1; s0 = startCount;
      applyStimulus(64'h3C00_4000_0000_3C00, 4'b1001, 64'h4200_0000_0000_4000, 4'b1001);
      waitOutValid(k);
      staleReady = 1'b0;
      checkOutput("latency_add_path", 64'(k), 64'd5);
      held = packOut(); bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (packOut() !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      checkOutput("backpressure_hold", 64'(bad), 64'd0);
      checkOutput("single_start_pulse", 64'(startCount - s0), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("release_handshake", {62'd0, out_valid, in_ready}, 64'd1);
      checkOutput("add_lanes_cleared", {60'd0, add_active_units}, 64'd0);
      waitDrain(1);

      // All-zero mask bypasses the adder.
      s0 = startCount;
      applyStimulus(64'h1111_2222_3333_4444, 4'b0000, 64'd0, 4'b0000);
      checkOutput("bypass_not_yet_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      checkOutput("bypass_valid_2cyc", {63'd0, out_valid}, 64'd1);
      waitDrain(2);
      checkOutput("bypass_no_start", 64'(startCount - s0), 64'd0);
      checkOutput("bypass_no_timeout", {63'd0, timeout_err}, 64'd0);

      // Adder never answers: timeout after TO wait cycles, then a normal row.
      adderMute = 1'b1;
      applyStimulus(64'h3C00_3C00_3C00_3C00, 4'b1111, 64'd0, 4'b0000);
      repeat (TO) @(negedge clk);
      checkOutput("timeout_not_early", {63'd0, timeout_err}, 64'd0);
      @(negedge clk);
      checkOutput("timeout_flag_set", {63'd0, timeout_err}, 64'd1);
      waitDrain(3);
      adderMute = 1'b0;
      applyStimulus(64'h3C00_3800_4000_0000, 4'b0110, 64'h0000_3E00_4000_0000, 4'b0110);
      waitDrain(4);
      checkOutput("timeout_sticky", {63'd0, timeout_err}, 64'd1);

      // Bias write on the accept edge: old value for this row, new one afterwards.
      writeBias(2'd0, 16'h4000);
      bias_wr_en = 1'b1; bias_wr_idx = 2'd0; bias_wr_data = 16'h4400;
      applyStimulus(64'h0000_0000_0000_3C00, 4'b0001, 64'h0000_0000_0000_4200, 4'b0001);
      bias_wr_en = 1'b0;
      waitDrain(5);
      applyStimulus(64'h0000_0000_0000_3C00, 4'b0001, 64'h0000_0000_0000_4500, 4'b0001);
      waitDrain(6);

      // Reset while waiting on the adder; its late ready must be ignored.
      applyStimulus(64'h3C00_3C00_3C00_3C00, 4'b1111, 64'd0, 4'b0000);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      checkOutput("async_reset_outputs",
                  {56'd0, in_ready, out_valid, add_start, timeout_err, add_active_units}, 64'd0);
      sbQ.delete();
      @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("in_ready_after_mid_reset", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      checkOutput("late_ready_ignored", {62'd0, out_valid, in_ready}, 64'd1);
      applyStimulus(64'h4400_3C00_4000_4200, 4'b1111, 64'h4400_3C00_4000_4200, 4'b1111);
      waitDrain(7);

      checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
